// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths, timer-slave register map.
// Pure declarations; no latency or backpressure of its own.
package apb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // 2'b11 is not a legal state; the master treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int TIMER_CTRL_OFS    = 0;
  localparam int TIMER_TIMEOUT_OFS = 1;

  // Wait-counter value at which the last allowed PREADY-low ACCESS cycle is reached.
  function automatic logic [7:0] wait_last(input int to_cycles);
    return 8'(to_cycles - 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts PREADY-low ACCESS cycles and flags the last allowed one; EXPIRED is combinational
// from the registered count. TO_CYCLES=0 never expires. No backpressure.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TO_CYCLES = 16
) (
  input  logic SYSCLK,
  input  logic RST,
  input  logic CLR,
  input  logic INC,
  output logic EXPIRED
);

  localparam logic [7:0] LAST = wait_last(TO_CYCLES);

  if (TO_CYCLES < 0 || TO_CYCLES > 255) begin : g_bad_to_cycles
    $error("apb_wait_timer: TO_CYCLES must be in 0..255");
  end

  logic [7:0] wait_cnt;

  // Saturate so an unlimited wait (TO_CYCLES=0) cannot wrap the counter.
  always_ff @(posedge SYSCLK) begin
    if (RST || CLR) begin
      wait_cnt <= '0;
    end else if (INC && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign EXPIRED = (TO_CYCLES != 0) && (wait_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: command handshake -> SETUP -> ACCESS (+ wait states) -> one-cycle response, 3 cycles min.
// CMD_READY only in IDLE or in a completing ACCESS cycle; responses are never backpressured.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TO_CYCLES = 16
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_t state;
  logic       in_access;
  logic       cmd_hs;
  logic       expired;
  logic       wait_clr;
  logic       wait_inc;

  assign in_access = (state == ACCESS);
  assign CMD_READY = !RST && ((state == IDLE) || (in_access && PREADY));
  assign cmd_hs    = CMD_VALID && CMD_READY;
  assign wait_clr  = (state == SETUP);
  assign wait_inc  = in_access && !PREADY && !expired;

  apb_wait_timer #(
    .TO_CYCLES(TO_CYCLES)
  ) u_wait_timer (
    .SYSCLK (SYSCLK),
    .RST    (RST),
    .CLR    (wait_clr),
    .INC    (wait_inc),
    .EXPIRED(expired)
  );

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            PWRITE  <= CMD_WRITE;
            PADDR   <= CMD_ADDR;
            PWDATA  <= CMD_WDATA;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= PWRITE ? '0 : PRDATA;
            // A command accepted on the completing edge goes straight to SETUP.
            if (cmd_hs) begin
              PWRITE  <= CMD_WRITE;
              PADDR   <= CMD_ADDR;
              PWDATA  <= CMD_WDATA;
              PENABLE <= 1'b0;
              state   <= SETUP;
            end else begin
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
              state   <= IDLE;
            end
          end else if (expired) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: transaction-level timing model, APB slave with scripted wait states.
module tb_apb_master;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int TO_CYCLES = 16;
  localparam int STUCK     = 1000;

  logic              SYSCLK = 1'b0;
  logic              RST = 1'b1;
  logic              CMD_VALID = 1'b0;
  logic              CMD_READY;
  logic              CMD_WRITE = 1'b0;
  logic [ADDR_W-1:0] CMD_ADDR = '0;
  logic [DATA_W-1:0] CMD_WDATA = '0;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  always #5 SYSCLK = ~SYSCLK;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYCLES(TO_CYCLES)) dut (
    .SYSCLK(SYSCLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (i == 1) ? 32'h0000_0040 : 32'h0000_0100 + 32'(i);
  endfunction

  // Wait-state count the slave applies to the transfer being started (stimulus, not expectation).
  int cmd_wait = 0;
  int m_cur_wait = 0;

  // ---------------- APB slave ----------------
  logic [DATA_W-1:0] smem [32];
  int acc_cnt = 0;
  int slv_wait = 0;

  assign PRDATA = (PSEL && !PWRITE) ? smem[PADDR] : 32'hDEAD_BEEF;
  assign PREADY = !(PSEL && PENABLE) || (acc_cnt >= slv_wait);

  always @(posedge SYSCLK) begin
    if (RST) begin
      acc_cnt <= 0;
      for (int i = 0; i < 32; i++) smem[i] <= init_val(i);
    end else begin
      if (PSEL && !PENABLE) slv_wait <= m_cur_wait;
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    end
  end

  // ---------------- Transaction-level model ----------------
  // Cycle k is the period after rising edge k. A transfer accepted at edge e is in SETUP
  // during cycle e, in ACCESS from e+1, and finishes at edge e+2+wait, or at e+1+TO on abort.
  int   cyc = 0;
  int   m_start = 0, m_end = 0, m_hs_cnt = 0;
  bit   m_busy = 0, m_abort = 0, m_rdy = 1, m_live = 0;
  logic m_pwrite = 0, m_rvld = 0, m_err = 0;
  logic [ADDR_W-1:0] m_paddr = '0;
  logic [DATA_W-1:0] m_pwdata = '0, m_rdata = '0;
  logic [DATA_W-1:0] mm [32];

  initial begin
    bit hs;
    forever begin
      @(posedge SYSCLK);
      cyc++;
      m_rvld = 0;
      if (RST) begin
        m_live = 1; m_busy = 0; m_abort = 0;
        m_pwrite = 0; m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_err = 0;
        for (int i = 0; i < 32; i++) mm[i] = init_val(i);
      end else if (m_live) begin
        hs = CMD_VALID && m_rdy;
        if (m_busy && cyc == m_end) begin
          m_busy = 0;
          m_rvld = 1;
          if (m_abort) begin
            m_err = 1; m_rdata = '0;
          end else begin
            m_err = 0;
            m_rdata = m_pwrite ? '0 : mm[m_paddr];
            if (m_pwrite) mm[m_paddr] = m_pwdata;
          end
        end
        if (hs) begin
          m_hs_cnt++;
          m_busy = 1; m_start = cyc; m_cur_wait = cmd_wait;
          m_pwrite = CMD_WRITE; m_paddr = CMD_ADDR; m_pwdata = CMD_WDATA;
          m_abort = (TO_CYCLES != 0) && (cmd_wait >= TO_CYCLES);
          m_end = m_abort ? cyc + 1 + TO_CYCLES : cyc + 2 + cmd_wait;
        end
      end
      m_rdy = !m_busy || (cyc == m_end - 1 && !m_abort);
    end
  end

  // ---------------- Per-cycle compare and monitors ----------------
  int psel_cyc = 0, pen_cyc = 0, psel_rise = 0, pwrite_sel = 0, acc_change = 0;
  int rsp_n = 0, rsp_cyc_last = 0, rsp_cyc_prev = 0;
  logic [DATA_W-1:0] rsp_dat_last = '0;
  logic rsp_err_last = 0;

  initial begin
    logic prev_psel;
    logic [ADDR_W-1:0] prev_paddr;
    logic [DATA_W-1:0] prev_pwdata;
    prev_psel = 0; prev_paddr = '0; prev_pwdata = '0;
    forever begin
      @(negedge SYSCLK);
      if (m_live) begin
        chk("cmd_ready", 32'(CMD_READY), 32'(!RST && m_rdy));
        chk("psel",      32'(PSEL),      32'(m_busy));
        chk("penable",   32'(PENABLE),   32'(m_busy && cyc > m_start));
        chk("pwrite",    32'(PWRITE),    32'(m_pwrite));
        chk("paddr",     32'(PADDR),     32'(m_paddr));
        chk("pwdata",    PWDATA,         m_pwdata);
        chk("rsp_valid", 32'(RSP_VALID), 32'(m_rvld));
        chk("rsp_rdata", RSP_RDATA,      m_rdata);
        chk("rsp_err",   32'(RSP_ERR),   32'(m_err));
        if (PSEL) psel_cyc++;
        if (PENABLE) pen_cyc++;
        if (PSEL && !prev_psel) psel_rise++;
        if (PSEL && PWRITE) pwrite_sel++;
        if (PENABLE && (PADDR != prev_paddr || PWDATA != prev_pwdata)) acc_change++;
        if (RSP_VALID) begin
          rsp_n++;
          rsp_cyc_prev = rsp_cyc_last; rsp_cyc_last = cyc;
          rsp_dat_last = RSP_RDATA; rsp_err_last = RSP_ERR;
        end
        prev_psel = PSEL; prev_paddr = PADDR; prev_pwdata = PWDATA;
      end
    end
  end

  // ---------------- Directed scenarios ----------------
  int b_psel, b_pen, b_rise, b_pwsel, b_chg, b_rsp;

  task automatic snap();
    b_psel = psel_cyc; b_pen = pen_cyc; b_rise = psel_rise;
    b_pwsel = pwrite_sel; b_chg = acc_change; b_rsp = rsp_n;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic send(input bit w, input int a, input logic [DATA_W-1:0] d, input int wt);
    int  h0;
    bit  got;
    CMD_VALID = 1; CMD_WRITE = w; CMD_ADDR = a[ADDR_W-1:0]; CMD_WDATA = d; cmd_wait = wt;
    h0 = m_hs_cnt; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge SYSCLK); #1;
      if (m_hs_cnt != h0) got = 1;
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL handshake_timeout: got no handshake expected one within 100 cycles");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge SYSCLK); #1;
      if (!m_busy) done = 1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: transfer still busy after %0d cycles expected done", budget);
    end
    settle(2);
  endtask

  initial begin
    // Reset
    RST = 1;
    settle(3);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    RST = 0;
    settle(1);
    chk("idle_ready", 32'(CMD_READY), 32'd1);

    // Zero-wait write of 6 to CTRL
    snap();
    send(1, 0, 32'h0000_0006, 0);
    CMD_VALID = 0;
    wait_idle(20);
    chk("wr_psel_cycles", 32'(psel_cyc - b_psel), 32'd2);
    chk("wr_pen_cycles", 32'(pen_cyc - b_pen), 32'd1);
    chk("wr_rsp_count", 32'(rsp_n - b_rsp), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err_last), 32'd0);
    chk("wr_rsp_rdata", rsp_dat_last, 32'd0);
    chk("wr_pwdata_hold", PWDATA, 32'h0000_0006);

    // Read TIMEOUT register
    snap();
    send(0, 1, 32'h0, 0);
    CMD_VALID = 0;
    wait_idle(20);
    chk("rd_rdata", rsp_dat_last, 32'h0000_0040);
    chk("rd_err", 32'(rsp_err_last), 32'd0);
    chk("rd_pwrite_low", 32'(pwrite_sel - b_pwsel), 32'd0);

    // Back-to-back write then read of address 1
    snap();
    send(1, 1, 32'h0000_0010, 0);
    send(0, 1, 32'h0, 0);
    CMD_VALID = 0;
    wait_idle(20);
    chk("b2b_rsp_count", 32'(rsp_n - b_rsp), 32'd2);
    chk("b2b_rsp_gap", 32'(rsp_cyc_last - rsp_cyc_prev), 32'd2);
    chk("b2b_rdata", rsp_dat_last, 32'h0000_0010);
    chk("b2b_psel_rise", 32'(psel_rise - b_rise), 32'd1);
    chk("b2b_psel_cycles", 32'(psel_cyc - b_psel), 32'd4);

    // Three wait states
    snap();
    send(1, 2, 32'hA5A5_0001, 3);
    CMD_VALID = 0;
    wait_idle(30);
    chk("ws_access_cycles", 32'(pen_cyc - b_pen), 32'd4);
    chk("ws_bus_stable", 32'(acc_change - b_chg), 32'd0);
    chk("ws_err", 32'(rsp_err_last), 32'd0);

    // Hung slave: abort after TO_CYCLES ACCESS cycles
    snap();
    send(0, 3, 32'h0, STUCK);
    CMD_VALID = 0;
    wait_idle(60);
    chk("to_access_cycles", 32'(pen_cyc - b_pen), 32'd16);
    chk("to_rsp_count", 32'(rsp_n - b_rsp), 32'd1);
    chk("to_err", 32'(rsp_err_last), 32'd1);
    chk("to_rdata", rsp_dat_last, 32'd0);
    chk("to_ready_after", 32'(CMD_READY), 32'd1);

    // PREADY arrives in the last allowed cycle: normal completion
    snap();
    send(0, 3, 32'h0, TO_CYCLES - 1);
    CMD_VALID = 0;
    wait_idle(60);
    chk("edge_access_cycles", 32'(pen_cyc - b_pen), 32'd16);
    chk("edge_err", 32'(rsp_err_last), 32'd0);
    chk("edge_rdata", rsp_dat_last, 32'h0000_0103);

    // Reset during ACCESS kills the transfer without a response
    snap();
    send(1, 4, 32'h0000_0077, 5);
    CMD_VALID = 0;
    settle(1);
    chk("kill_in_access", 32'(PENABLE), 32'd1);
    RST = 1;
    settle(1);
    chk("kill_psel", 32'(PSEL), 32'd0);
    chk("kill_penable", 32'(PENABLE), 32'd0);
    RST = 0;
    settle(5);
    chk("kill_no_rsp", 32'(rsp_n - b_rsp), 32'd0);
    send(0, 4, 32'h0, 0);
    CMD_VALID = 0;
    wait_idle(20);
    chk("post_kill_rsp", 32'(rsp_n - b_rsp), 32'd1);
    chk("post_kill_rdata", rsp_dat_last, 32'h0000_0104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
